// File: rtl/uart_frame_parser_if.sv
// Byte-in / register-write-out bundle between the UART receiver, the frame
// parser and the local register space.
interface uart_frame_parser_if;
  logic [7:0] Rx_Data;
  logic       Rx_Done;
  logic       Wr_En;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Frame_Ok;
  logic       Frame_Err;
  logic [1:0] Err_Code;
  logic       Busy;

  // master: byte source side (UART receiver / bench)
  modport master (
    output Rx_Data, Rx_Done,
    input  Wr_En, Wr_Addr, Wr_Data, Frame_Ok, Frame_Err, Err_Code, Busy
  );

  // slave: the frame parser
  modport slave (
    input  Rx_Data, Rx_Done,
    output Wr_En, Wr_Addr, Wr_Data, Frame_Ok, Frame_Err, Err_Code, Busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SOF ADDR LEN payload CHK.
// Payload is held until the checksum verifies, then replayed as a burst of
// register writes at ADDR, ADDR+1, ... (8-bit wrap). Bad frames are dropped
// with a one-cycle error pulse and a sticky error code.
module uart_frame_parser #(
  parameter logic [7:0] SOF            = 8'h55,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic              Clk,
  input  logic              Reset,
  uart_frame_parser_if.slave bus
);
  localparam int CW = $clog2(MAX_LEN + 1);                 // index / length width
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;  // buffer address width
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);           // timeout counter width

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam logic [1:0] E_LEN = 2'd1;
  localparam logic [1:0] E_TMO = 2'd2;
  localparam logic [1:0] E_CHK = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [CW-1:0] len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic          buf_we;

  logic [7:0] pbuf_q [0:(1<<AW)-1];

  // Next-state logic: byte consumption, timeout and write-burst sequencing
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    busy_d    = (state_q != S_IDLE);  // lags state by one cycle on both edges
    buf_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (bus.Rx_Done && bus.Rx_Data == SOF) state_d = S_ADDR;
      end

      S_ADDR, S_LEN, S_PAYLOAD, S_CHK: begin
        // A byte arriving on the terminal-count edge takes priority.
        if (bus.Rx_Done) begin
          tmo_d = '0;
          case (state_q)
            S_ADDR: begin
              addr_d  = bus.Rx_Data;
              sum_d   = bus.Rx_Data;
              state_d = S_LEN;
            end
            S_LEN: begin
              if (bus.Rx_Data == 8'd0 || bus.Rx_Data > LEN_MAX) begin
                err_d   = 1'b1;
                code_d  = E_LEN;
                state_d = S_IDLE;
              end else begin
                len_d   = bus.Rx_Data[CW-1:0];
                sum_d   = sum_q + bus.Rx_Data;
                idx_d   = '0;
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              buf_we = 1'b1;
              sum_d  = sum_q + bus.Rx_Data;
              if (idx_q == len_q - CNT_ONE) begin
                idx_d   = '0;
                state_d = S_CHK;
              end else begin
                idx_d = idx_q + CNT_ONE;
              end
            end
            default: begin  // S_CHK
              if (bus.Rx_Data == sum_q) begin
                idx_d   = '0;
                state_d = S_DRAIN;
              end else begin
                err_d   = 1'b1;
                code_d  = E_CHK;
                state_d = S_IDLE;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = E_TMO;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      S_DRAIN: begin
        // Incoming bytes are ignored here; one write per cycle.
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q + 8'(idx_q);
        wr_data_d = pbuf_q[idx_q[AW-1:0]];
        if (idx_q == len_q - CNT_ONE) begin
          ok_d    = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  // Payload storage; contents are only read back after a verified checksum
  always_ff @(posedge Clk) begin
    if (buf_we) pbuf_q[idx_q[AW-1:0]] <= bus.Rx_Data;
  end

  assign bus.Wr_En     = wr_en_q;
  assign bus.Wr_Addr   = wr_addr_q;
  assign bus.Wr_Data   = wr_data_q;
  assign bus.Frame_Ok  = ok_q;
  assign bus.Frame_Err = err_q;
  assign bus.Err_Code  = code_q;
  assign bus.Busy      = busy_q;
endmodule
